// File: rtl/fc_act_loader.sv
// Serial activation loader, settle timer and result register wrapped around one combinational
// fully-connected layer. Defining FC_ACT_LOADER_LAST_CHK_EN adds the s_last/err framing check.
module fc_act_loader #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned IN      = 128,
   parameter int unsigned Z_WIDTH = 23,
   parameter int unsigned SETTLE  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WIDTH-1:0]    s_data,
   output logic [WIDTH*IN-1:0] x_vec,
   input  logic [Z_WIDTH-1:0]  z_in,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [Z_WIDTH-1:0]  m_data,
   output logic                busy
`ifdef FC_ACT_LOADER_LAST_CHK_EN
   ,
   input  logic                s_last,
   output logic                err
`endif
);

   localparam int unsigned     IdxW      = (IN > 1) ? $clog2(IN) : 1;
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(IN - 1);
   localparam logic [7:0]      SettleCnt = 8'(SETTLE);

   typedef enum logic [1:0] {StFill, StSettle, StOut} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [WIDTH*IN-1:0]   x_vec_q, x_vec_d;
   logic [Z_WIDTH-1:0]    m_data_q, m_data_d;
   logic                  accept;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      x_vec_d  = x_vec_q;
      m_data_d = m_data_q;
      s_ready  = 1'b0;
      accept   = 1'b0;
      unique case (state_q)
         StFill: begin
            // Held low while rst is asserted so no beat is ever offered a handshake in reset.
            s_ready = ~rst;
            if (s_valid && s_ready) begin
               accept = 1'b1;
               x_vec_d[WIDTH*idx_q +: WIDTH] = s_data;
               if (idx_q == IdxLast) begin
                  idx_d   = '0;
                  cnt_d   = SettleCnt;
                  state_d = StSettle;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StSettle: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               m_data_d = z_in;
               state_d  = StOut;
            end
         end
         StOut: begin
            if (m_ready) state_d = StFill;
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFill;
         idx_q    <= '0;
         cnt_q    <= '0;
         x_vec_q  <= '0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         x_vec_q  <= x_vec_d;
         m_data_q <= m_data_d;
      end
   end

   assign x_vec   = x_vec_q;
   assign m_data  = m_data_q;
   assign m_valid = (state_q == StOut);
   assign busy    = !((state_q == StFill) && (idx_q == '0));

`ifdef FC_ACT_LOADER_LAST_CHK_EN
   logic err_q, err_d;

   // Sticky: any accepted beat whose s_last disagrees with the vector position.
   always_comb begin
      err_d = err_q;
      if (accept && (s_last != (idx_q == IdxLast))) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed self-checking bench for fc_act_loader; z_in comes from a small weighted-sum layer
// stand-in. Also exercises the s_last check when FC_ACT_LOADER_LAST_CHK_EN is defined.
module tb_fc_act_loader;

   localparam int WIDTH   = 8;
   localparam int IN      = 128;
   localparam int Z_WIDTH = 23;
   localparam int SETTLE  = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [WIDTH-1:0]    s_data = '0;
   logic [WIDTH*IN-1:0] x_vec;
   logic [Z_WIDTH-1:0]  z_in;
   logic                m_valid;
   logic                m_ready = 1'b1;
   logic [Z_WIDTH-1:0]  m_data;
   logic                busy;
   logic                s_last_tb = 1'b0;
`ifdef FC_ACT_LOADER_LAST_CHK_EN
   logic                err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] xv [IN];
   int z_acc;

   fc_act_loader #(
      .WIDTH   (WIDTH),
      .IN      (IN),
      .Z_WIDTH (Z_WIDTH),
      .SETTLE  (SETTLE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .x_vec   (x_vec),
      .z_in    (z_in),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .busy    (busy)
`ifdef FC_ACT_LOADER_LAST_CHK_EN
      ,
      .s_last  (s_last_tb),
      .err     (err)
`endif
   );

   always #5 clk = ~clk;

   // Layer stand-in: z = sum x[i] * ((i % 5) + 1), unsigned so ReLU is the identity.
   always_comb begin
      z_acc = 0;
      for (int i = 0; i < IN; i++) z_acc += int'(x_vec[WIDTH*i +: WIDTH]) * ((i % 5) + 1);
      z_in = z_acc[Z_WIDTH-1:0];
   end

   function automatic logic [63:0] model_z();
      int acc = 0;
      for (int i = 0; i < IN; i++) acc += int'(xv[i]) * ((i % 5) + 1);
      return 64'(acc[Z_WIDTH-1:0]);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag);
      int bad = -1;
      logic [7:0] o = '0;
      logic [7:0] e = '0;
      for (int i = 0; i < IN; i++) begin
         if (bad < 0 && x_vec[WIDTH*i +: WIDTH] !== xv[i]) begin
            bad = i;
            o   = x_vec[WIDTH*i +: WIDTH];
            e   = xv[i];
         end
      end
      n_checks++;
      assert (bad < 0) else begin
         n_errors++;
         $error("FAIL %s: element %0d observed %0h expected %0h", tag, bad, o, e);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic last, output int waited);
      waited    = 0;
      s_valid   = 1'b1;
      s_data    = d;
      s_last_tb = last;
      while (!s_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("send_ready", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      s_valid   = 1'b0;
      s_last_tb = 1'b0;
   endtask

   task automatic wait_mvalid(output int edges);
      edges = 0;
      while (!m_valid && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int total_wait;
      int edges;
      int bad;
      logic [Z_WIDTH-1:0]  md;
      logic [WIDTH*IN-1:0] xs;

      // Reset state
      @(posedge clk); #1;
      for (int i = 0; i < IN; i++) xv[i] = 8'h00;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk_vec("rst_x_vec");
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", 64'(s_ready), 64'd1);

      // Ungapped fill and capture
      total_wait = 0;
      for (int i = 0; i < IN; i++) begin
         xv[i] = 8'(i);
         send(8'(i), i == IN - 1, w);
         total_wait += w;
      end
      chk("fill_no_stall", 64'(total_wait), 64'd0);
      chk("settle_s_ready", 64'(s_ready), 64'd0);
      chk("settle_busy", 64'(busy), 64'd1);
      chk("settle_m_valid0", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      chk("settle_m_valid1", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      chk("out_m_valid", 64'(m_valid), 64'd1);
      chk("out_m_data", 64'(m_data), model_z());
      chk("out_s_ready", 64'(s_ready), 64'd0);
      chk_vec("fill_x_vec");
      @(posedge clk); #1;
      chk("hs_m_valid", 64'(m_valid), 64'd0);
      chk("hs_s_ready", 64'(s_ready), 64'd1);
      chk("hs_busy", 64'(busy), 64'd0);
`ifdef FC_ACT_LOADER_LAST_CHK_EN
      chk("err_clean", 64'(err), 64'd0);
`endif

      // Bubbly input with output held back
      m_ready = 1'b0;
      for (int i = 0; i < IN; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         xv[i] = 8'(i) ^ 8'h5A;
         send(8'(i) ^ 8'h5A, i == IN - 1, w);
         if (i == IN - 2) chk("bubbly_no_early_valid", 64'(m_valid), 64'd0);
      end
      // Offered beat must be ignored during SETTLE and OUT
      s_valid = 1'b1;
      s_data  = 8'hAA;
      wait_mvalid(edges);
      chk("bubbly_latency", 64'(edges), 64'd2);
      chk("bubbly_m_data", 64'(m_data), model_z());
      chk_vec("bubbly_x_vec");

      md  = m_data;
      xs  = x_vec;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (m_valid !== 1'b1 || m_data !== md || s_ready !== 1'b0 || x_vec !== xs) bad++;
      end
      chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
      chk_vec("bp_x_vec");

      m_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_m_valid", 64'(m_valid), 64'd0);
      chk("bp_hs_s_ready", 64'(s_ready), 64'd1);
      chk("bp_hs_busy", 64'(busy), 64'd0);

      // First beat after s_ready rises is the held 8'hAA; then reset after 60 beats
      xv[0] = 8'hAA;
      send(8'hAA, 1'b0, w);
      chk("aa_busy", 64'(busy), 64'd1);
      chk("aa_elem0", 64'(x_vec[WIDTH-1:0]), 64'hAA);
      for (int i = 1; i < 60; i++) send(8'(i * 3), 1'b0, w);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < IN; i++) xv[i] = 8'h00;
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_m_data", 64'(m_data), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk_vec("midrst_x_vec");
      rst = 1'b0;
      #1;
      chk("midrst_after_s_ready", 64'(s_ready), 64'd1);

      for (int i = 0; i < IN; i++) begin
         xv[i] = 8'(255 - i);
         send(8'(255 - i), i == IN - 1, w);
         if (i == IN - 2) chk("refill_no_early_valid", 64'(m_valid), 64'd0);
      end
      wait_mvalid(edges);
      chk("refill_latency", 64'(edges), 64'd2);
      chk("refill_m_data", 64'(m_data), model_z());
      chk_vec("refill_x_vec");
      @(posedge clk); #1;
      chk("refill_hs_m_valid", 64'(m_valid), 64'd0);

`ifdef FC_ACT_LOADER_LAST_CHK_EN
      // Misplaced s_last on beat 100
      chk("last_err_before", 64'(err), 64'd0);
      for (int i = 0; i < IN; i++) begin
         xv[i] = 8'(i * 7);
         send(8'(i * 7), i == 100, w);
         if (i == 99)  chk("last_err_pre100", 64'(err), 64'd0);
         if (i == 100) chk("last_err_set", 64'(err), 64'd1);
      end
      wait_mvalid(edges);
      chk("last_latency", 64'(edges), 64'd2);
      chk("last_m_data", 64'(m_data), model_z());
      chk("last_err_held", 64'(err), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("last_err_cleared", 64'(err), 64'd0);
      rst = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
